// File: rtl/conv_engine.sv
// Parallel N-tap convolution engine: reads the X/F memories whole, emits y[k] for k=0..M-N over valid/ready.
// Optional macro CONV_RELU_EN clamps negative results to zero at the output stage.
module conv_engine #(
  parameter int WIDTH = 16,
  parameter int M     = 16,
  parameter int N     = 8,
  parameter int LOGM  = 4,
  parameter int LOGN  = 3,
  parameter int ACCW  = 35
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_mem [M],
  input  logic signed [WIDTH-1:0] f_mem [N],
  output logic                    busy,
  output logic                    done,
  output logic signed [ACCW-1:0]  out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int XIW = (M > 1) ? $clog2(M) : 1;
  localparam int PW  = 2 * WIDTH;
  localparam logic [LOGM-1:0] K_LAST = LOGM'(M - N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [LOGM-1:0]        r_k;
  logic                   r_s1_valid;
  logic signed [PW-1:0]   r_prod [N];
  logic signed [PW-1:0]   w_prod [N];
  logic                   r_out_valid;
  logic signed [ACCW-1:0] r_out_data;
  logic signed [ACCW-1:0] w_sum;
  logic signed [ACCW-1:0] w_result;
  logic                   w_enable;
  logic                   w_issue;

  // Whole pipeline freezes while a presented result is not being accepted.
  assign w_enable = !(r_out_valid && !out_ready);
  assign w_issue  = (r_state == S_RUN) && w_enable;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_tap
      logic [XIW-1:0] w_idx;
      assign w_idx      = XIW'(r_k) + XIW'(gi);
      assign w_prod[gi] = PW'(x_mem[w_idx]) * PW'(f_mem[gi]);
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = w_sum + ACCW'(r_prod[i]);
    end
  end

`ifdef CONV_RELU_EN
  assign w_result = w_sum[ACCW-1] ? '0 : w_sum;
`else
  assign w_result = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_issue && (r_k == K_LAST)) w_state_next = S_DRAIN;
      // Leave once stage 1 is empty and the final result is handshaking now.
      S_DRAIN: if (!r_s1_valid && (!r_out_valid || out_ready)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k         <= '0;
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_enable) begin
      r_s1_valid  <= w_issue;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_result;
      end
      if (w_issue) begin
        r_k <= r_k + LOGM'(1);
      end else if ((r_state == S_IDLE) && start) begin
        r_k <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      for (int i = 0; i < N; i++) begin
        r_prod[i] <= w_prod[i];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
